// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the boot-time program loader:
//   - loader_state_e : loader FSM states
//   - stream-order constants describing the byte stream layout
//   - LOADER_LEN_W   : width of the word-count field and word counter
// ---------------------------------------------------------------------------
package loader_pkg;

   localparam int LOADER_LEN_W = 16;

   // Stream layout: LEN_HI, LEN_LO, then N x (HI, LO), then CHK.
   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 2;
   localparam int CHK_BYTES  = 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LEN_HI  = 3'd1,
      LEN_LO  = 3'd2,
      DATA_HI = 3'd3,
      DATA_LO = 3'd4,
      CHK     = 3'd5,
      DONE    = 3'd6,
      ERR     = 3'd7
   } loader_state_e;

   // States in which the loader consumes stream bytes.
   function automatic logic is_rx_state(input loader_state_e s);
      return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
             (s == DATA_LO) || (s == CHK);
   endfunction

endpackage

// File: rtl/word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Latches the HI byte of an instruction word, forms {hi, lo} when the LO
// byte is accepted and issues a registered one-cycle write strobe.
// Ports:
//   clock, clr       : clock, synchronous active-low reset
//   hi_load_i        : HI byte accepted this cycle
//   lo_load_i        : LO byte accepted this cycle
//   byte_i           : stream byte
//   addr_i           : word address for the word completing this cycle
//   we_o             : write strobe, high the cycle after the LO accept
//   addr_o, wdata_o  : registered write address / data, stable while we_o
// ---------------------------------------------------------------------------
module word_assembler #(
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              clr,
   input  logic              hi_load_i,
   input  logic              lo_load_i,
   input  logic [7:0]        byte_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [15:0]       wdata_o
);

   logic [7:0]        hi_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;

   always_ff @(posedge clock) begin
      if (!clr) begin
         hi_q    <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         we_q <= lo_load_i;
         if (hi_load_i) begin
            hi_q <= byte_i;
         end
         // Address and data hold their value after the strobe so the
         // memory sees a stable bus for the whole write cycle.
         if (lo_load_i) begin
            wdata_q <= {hi_q, byte_i};
            addr_q  <= addr_i;
         end
      end
   end

   assign we_o    = we_q;
   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Boot loader in front of the instruction memory. Receives a byte stream
// (LEN_HI, LEN_LO, N x {HI, LO}, CHK) over valid/ready, writes the words
// from address 0 and keeps the processor held until a checksum-verified
// image has been loaded.
// Handshake: a byte transfers on a rising edge where rx_valid & rx_ready
// is 1; rx_valid is ignored while rx_ready is 0.
// Ports:
//   clock, clr         : clock, synchronous active-low reset
//   start              : begin a load (honoured in IDLE, DONE, ERR)
//   rx_valid, rx_byte  : byte stream input
//   rx_ready           : loader accepts a byte this cycle
//   imem_we            : one-cycle instruction memory write strobe
//   imem_addr          : word write address
//   imem_wdata         : instruction word {hi, lo}
//   cpu_hold           : 1 keeps the processor PC in reset
//   done, err          : load result levels
//   dbg_state_o        : current FSM state, for observation
// All outputs are registered.
// ---------------------------------------------------------------------------
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              clr,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output loader_state_e     dbg_state_o
);

   // Largest legal word count, 2^ADDR_W, held one bit wider than the length
   // field so a full 16-bit address space still compares correctly.
   localparam logic [LOADER_LEN_W:0] CAPACITY =
      {{LOADER_LEN_W{1'b0}}, 1'b1} << ADDR_W;

   loader_state_e           state_q, state_d;
   logic [LOADER_LEN_W-1:0] cnt_q, cnt_d;
   logic [LOADER_LEN_W-1:0] len_q, len_d;
   logic [7:0]              xor_q, xor_d;
   logic                    rx_ready_q, rx_ready_d;
   logic                    hold_q, hold_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    hi_load, lo_load;
   logic                    accept;
   logic [LOADER_LEN_W-1:0] len_word;

   assign accept   = rx_valid & rx_ready_q;
   assign len_word = {len_q[LOADER_LEN_W-1:8], rx_byte};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      xor_d   = xor_q;
      hi_load = 1'b0;
      lo_load = 1'b0;

      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = LEN_HI;
               cnt_d   = '0;
               xor_d   = '0;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d[LOADER_LEN_W-1:8] = rx_byte;
               xor_d   = xor_q ^ rx_byte;
               state_d = LEN_LO;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_d = len_word;
               xor_d = xor_q ^ rx_byte;
               if (len_word == '0) begin
                  state_d = CHK;
               end else if ({1'b0, len_word} > CAPACITY) begin
                  state_d = ERR;
               end else begin
                  state_d = DATA_HI;
               end
            end
         end
         DATA_HI: begin
            if (accept) begin
               hi_load = 1'b1;
               xor_d   = xor_q ^ rx_byte;
               state_d = DATA_LO;
            end
         end
         DATA_LO: begin
            if (accept) begin
               lo_load = 1'b1;
               xor_d   = xor_q ^ rx_byte;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == len_q - 1'b1) begin
                  state_d = CHK;
               end else begin
                  state_d = DATA_HI;
               end
            end
         end
         CHK: begin
            if (accept) begin
               state_d = (rx_byte == xor_q) ? DONE : ERR;
            end
         end
         default: state_d = IDLE;
      endcase

      // Status outputs are registered versions of the next state.
      rx_ready_d = is_rx_state(state_d);
      hold_d     = (state_d != DONE);
      done_d     = (state_d == DONE);
      err_d      = (state_d == ERR);
   end

   always_ff @(posedge clock) begin
      if (!clr) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         xor_q      <= '0;
         rx_ready_q <= 1'b0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         xor_q      <= xor_d;
         rx_ready_q <= rx_ready_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   word_assembler #(
      .ADDR_W (ADDR_W)
   ) u_word_assembler (
      .clock     (clock),
      .clr       (clr),
      .hi_load_i (hi_load),
      .lo_load_i (lo_load),
      .byte_i    (rx_byte),
      .addr_i    (cnt_q[ADDR_W-1:0]),
      .we_o      (imem_we),
      .addr_o    (imem_addr),
      .wdata_o   (imem_wdata)
   );

   assign rx_ready    = rx_ready_q;
   assign cpu_hold    = hold_q;
   assign done        = done_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Directed vectors for program_loader: a table of stream images with
// hand-computed results and writes, plus hand-written sequences for reset,
// full capacity, DONE backpressure and abort/restart.
// ---------------------------------------------------------------------------
module tb_program_loader;
   import loader_pkg::*;

   localparam int ADDR_W = 8;

   // ---------------- clock / reset ----------------
   logic              clock = 1'b0;
   logic              clr = 1'b0;
   logic              start = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_byte = 8'h00;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;
   loader_state_e     dbg_state;

   always #5 clock = ~clock;

   program_loader #(.ADDR_W(ADDR_W)) dut (
      .clock       (clock),
      .clr         (clr),
      .start       (start),
      .rx_valid    (rx_valid),
      .rx_byte     (rx_byte),
      .rx_ready    (rx_ready),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .cpu_hold    (cpu_hold),
      .done        (done),
      .err         (err),
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;
   logic [23:0] exp_q[$];
   logic [23:0] got_q[$];
   logic [7:0]  stream_q[$];
   logic        we_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write monitor: records every strobe and checks it lasts one cycle.
   always @(negedge clock) begin
      if (imem_we) begin
         got_q.push_back({imem_addr, imem_wdata});
         checks++;
         if (we_prev) begin
            errors++;
            $display("FAIL we_pulse: got 2-cycle strobe expected 1-cycle at addr %0h", imem_addr);
         end
      end
      we_prev = imem_we;
   end

   task automatic compare_writes(input string name);
      logic [23:0] g, e;
      check({name, "_nwrites"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         check({name, "_write"}, {8'h0, g}, {8'h0, e});
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge after the byte's accept edge.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
      rx_valid = 1'b1;
      rx_byte  = b;
      n = 0;
      while (!rx_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("rx_ready_wait", rx_ready, 1'b1);
      @(posedge clock);
      @(negedge clock);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("start_rx_ready", rx_ready, 1'b1);
      check("start_hold", cpu_hold, 1'b1);
      check("start_done_clr", done, 1'b0);
      check("start_err_clr", err, 1'b0);
   endtask

   task automatic run_stream(input string name, input logic exp_done, input logic exp_err,
                             input bit gaps, input bit start_mid);
      pulse_start();
      for (int i = 0; i < stream_q.size(); i++) begin
         start = start_mid && (i > 0);
         send_byte(stream_q[i], gaps);
      end
      start = 1'b0;
      check({name, "_done"}, done, exp_done);
      check({name, "_err"}, err, exp_err);
      check({name, "_hold"}, cpu_hold, !exp_done);
      check({name, "_rx_ready"}, rx_ready, 1'b0);
      @(negedge clock);
      compare_writes(name);
      stream_q.delete();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      int          nb;
      logic [63:0] bytes;   // first byte in the top 8 bits
      bit          gaps;
      logic        exp_done;
      logic        exp_err;
      int          nw;
      logic [47:0] writes;  // {addr, data} pairs, first in the top 24 bits
   } vec_t;

   vec_t vecs[7];

   task automatic run_vec(input vec_t v);
      logic [63:0] bb;
      logic [47:0] ww;
      bb = v.bytes;
      ww = v.writes;
      for (int i = 0; i < v.nb; i++) stream_q.push_back(bb[63-8*i -: 8]);
      for (int j = 0; j < v.nw; j++) exp_q.push_back(ww[47-24*j -: 24]);
      run_stream(v.name, v.exp_done, v.exp_err, v.gaps, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] x;
      vecs[0] = '{"good2",    7, 64'h0002_1234_ABCD_4200, 1'b0, 1'b1, 1'b0, 2, 48'h00_1234_01_ABCD};
      vecs[1] = '{"badchk",   7, 64'h0002_1234_ABCD_4300, 1'b0, 1'b0, 1'b1, 2, 48'h00_1234_01_ABCD};
      vecs[2] = '{"zero",     3, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 0, 48'h0};
      vecs[3] = '{"over257",  2, 64'h0101_0000_0000_0000, 1'b0, 1'b0, 1'b1, 0, 48'h0};
      vecs[4] = '{"gaps",     7, 64'h0002_1234_ABCD_4200, 1'b1, 1'b1, 1'b0, 2, 48'h00_1234_01_ABCD};
      vecs[5] = '{"one",      5, 64'h0001_55AA_FE00_0000, 1'b0, 1'b1, 1'b0, 1, 48'h00_55AA_000000};
      vecs[6] = '{"over8000", 2, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 0, 48'h0};

      // Reset, then idle with no start.
      repeat (2) @(negedge clock);
      check("rst_rx_ready", rx_ready, 1'b0);
      check("rst_we", imem_we, 1'b0);
      check("rst_addr", imem_addr, 8'h00);
      check("rst_wdata", imem_wdata, 16'h0000);
      check("rst_hold", cpu_hold, 1'b1);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      clr = 1'b1;
      repeat (5) @(negedge clock);
      check("idle_hold", cpu_hold, 1'b1);
      check("idle_rx_ready", rx_ready, 1'b0);
      check("idle_nwrites", got_q.size(), 0);

      // Table-driven images.
      for (int k = 0; k < 7; k++) begin
         run_vec(vecs[k]);
         if (k == 0) begin
            // rx_valid held high in DONE: nothing is consumed.
            rx_valid = 1'b1;
            rx_byte  = 8'h5A;
            repeat (4) begin
               @(negedge clock);
               check("done_rx_ready", rx_ready, 1'b0);
               check("done_stays", done, 1'b1);
            end
            rx_valid = 1'b0;
            check("done_nwrites", got_q.size(), 0);
         end
      end

      // Full capacity: 256 words, word i = {i, ~i}, last write at 0xFF.
      x = 8'h01;
      stream_q.push_back(8'h01);
      stream_q.push_back(8'h00);
      for (int i = 0; i < 256; i++) begin
         logic [7:0] hi, lo;
         hi = 8'(i);
         lo = ~hi;
         stream_q.push_back(hi);
         stream_q.push_back(lo);
         x = x ^ hi ^ lo;
         exp_q.push_back({hi, hi, lo});
      end
      stream_q.push_back(x);
      run_stream("full256", 1'b1, 1'b0, 1'b0, 1'b0);

      // Abort after the first word is written.
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      exp_q.push_back(24'h00_1234);
      check("abort_we", imem_we, 1'b1);
      @(negedge clock);
      compare_writes("abort_pre");
      clr = 1'b0;
      @(negedge clock);
      check("abort_hold", cpu_hold, 1'b1);
      check("abort_rx_ready", rx_ready, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_addr", imem_addr, 8'h00);
      check("abort_wdata", imem_wdata, 16'h0000);
      check("abort_state", dbg_state, IDLE);
      clr = 1'b1;
      @(negedge clock);

      // Restart with the good image while start is pulsed mid-load.
      stream_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
      exp_q.push_back(24'h00_1234);
      exp_q.push_back(24'h01_ABCD);
      run_stream("restart", 1'b1, 1'b0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader sitting directly upstream of the processor's instruction memory. Receives a byte stream over a valid/ready handshake, assembles 16-bit instruction words, writes them sequentially from address 0 into instruction memory, and holds the processor's program counter in reset until a complete, checksum-verified image is loaded. Once loading succeeds, it releases the processor and goes quiet until the next `start`.

## Interface
- `ADDR_W`, 8: instruction memory address width; capacity is 2^ADDR_W words.
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `clr`  in  1  reset, synchronous, active-low.
- `start`  in  1  begins a load; sampled only in IDLE, DONE or ERR.
- `rx_valid`  in  1  `rx_byte` is valid.
- `rx_byte`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_addr`  out  ADDR_W  word write address.
- `imem_wdata`  out  16  instruction word; `{hi, lo}`.
- `cpu_hold`  out  1  drives the PC `clr`; 1 keeps the processor held.
- `done`  out  1  image loaded and checksum good; level.
- `err`  out  1  length or checksum error; level.

## Operation
- Stream format: LEN_HI, LEN_LO (word count N, 16-bit, big-endian), then N × (HI byte, LO byte), then CHK.
- CHK is the XOR of every preceding byte, including the length bytes.
- A byte transfers on a rising edge where `rx_valid & rx_ready` is 1. When `rx_ready` is 0, `rx_valid` is ignored and the byte is not consumed.
- States and transitions:
  - IDLE: `start` → LEN_HI.
  - LEN_HI → LEN_LO on accept.
  - LEN_LO on accept:
    - N == 0 → CHK.
    - N > 2^ADDR_W → ERR; the CHK byte is not awaited.
    - otherwise → DATA_HI.
  - DATA_HI → DATA_LO on accept.
  - DATA_LO on accept: word counter == N−1 → CHK, else → DATA_HI.
  - CHK on accept: byte equals the running XOR → DONE, else → ERR.
  - DONE and ERR: `start` → LEN_HI. This clears `done`/`err`, reasserts `cpu_hold`, and resets the word counter and XOR accumulator.
- `start` in any other state is ignored.
- `rx_ready` = 1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK.
- Word counter is 16 bits, reset to 0 on entering LEN_HI, and incremented after each LO byte. `imem_addr` = counter[ADDR_W-1:0].
- The full capacity N = 2^ADDR_W is legal; the last write goes to address 2^ADDR_W−1. The 16-bit counter does not wrap within a legal image.
- `cpu_hold` = 1 in every state except DONE.
- Memory is never cleared. On ERR or reset, words already written remain in memory but the processor stays held.

## Timing
- Reset (`clr` = 0 at an edge): state IDLE, `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=1, `done`=0, `err`=0.
- Reset mid-load aborts at that edge with the same values.
- All outputs are registered.
- Write latency: `imem_we` is high for exactly one cycle, in the cycle after the LO byte is accepted. `imem_addr` and `imem_wdata` are stable during that cycle.
- For the last word, the write strobe coincides with the first CHK cycle.
- Because each word takes at least 2 cycles of accepts, writes never collide.
- The `done`/`err` rise and the `cpu_hold` fall take effect in the cycle after the CHK accept, or after the LEN_LO accept for an oversize N.
- Maximum throughput: one byte per cycle, with `rx_valid` held high.

## Structure
- Shared package `loader_pkg`:
  - state enum: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERR;
  - the stream-order constants;
  - `LOADER_LEN_W = 16`.
- One natural sub-module: `word_assembler`. It latches the HI byte, forms `{hi, lo}` on the LO accept, and generates the registered `imem_we` pulse.
- The FSM, word counter and XOR accumulator stay in `program_loader`.

## Test plan
- Reset then idle: `clr`=0 for 2 cycles, then 1 with no `start` → `cpu_hold`=1, `rx_ready`=0, `imem_we` never asserted.
- Good 2-word image: `start`, then 00 02 12 34 AB CD with CHK = 00^02^12^34^AB^CD = 0x42 → writes `addr0=0x1234`, `addr1=0xABCD`, each a single-cycle `imem_we`; `done`=1 and `cpu_hold`=0 one cycle after the CHK accept.
- Bad checksum: same image with CHK = 0x43 → both words written, `err`=1, `done`=0, `cpu_hold` remains 1.
- Zero and oversize length (`ADDR_W`=8):
  - 00 00 then CHK 00 → `done` with no writes.
  - 01 01 → `err` right after LEN_LO, no writes, `rx_ready`=0.
- Backpressure and gaps: the good image sent with random `rx_valid` gaps, plus `rx_valid` held high while in DONE → identical writes, and no byte is consumed in DONE.
- Abort and restart:
  - `clr` asserted after the first word is written → IDLE, `cpu_hold`=1.
  - Then `start` with the good image → `done`.
  - `start` pulsed mid-load → ignored.
